// File: rtl/uart_rx_engine.sv
// UART receive engine: synchronizes rx, finds the start bit, samples each bit at its centre
// and presents the assembled 7/8-bit byte with parity, framing and overrun status.
module uart_rx_engine #(
  parameter int unsigned KW          = 20,
  parameter int unsigned SYNC_STAGES = 2   // must be >= 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx,
  input  logic [KW-1:0] k,
  input  logic          eight,
  input  logic          pen,
  input  logic          ohel,
  input  logic          reads,
  output logic [7:0]    rx_data,
  output logic          rx_ready,
  output logic          perr,
  output logic          ferr,
  output logic          ovf
);

  typedef enum logic [1:0] {StIdle, StStart, StData, StDone} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [KW-1:0]          cnt_q, cnt_d;
  logic [3:0]             bitcnt_q, bitcnt_d;
  logic [9:0]             shreg_q, shreg_d;
  logic                   eight_q, eight_d, pen_q, pen_d, ohel_q, ohel_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   rx_ready_q, rx_ready_d;
  logic                   perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d;

  logic          rxs;
  logic [KW-1:0] target;
  logic          tick;
  logic [3:0]    nsamp;
  logic [7:0]    frame;
  logic [7:0]    data;

  assign rxs = sync_q[SYNC_STAGES-1];

  // Half a bit in START lands the first data sample at the centre of bit 0.
  assign target = (state_q == StStart) ? (k >> 1) : k;
  assign tick   = (cnt_q == target - KW'(1));

  // Samples after the start bit: data bits, optional parity, stop.
  assign nsamp = 4'd8 + {3'd0, eight_q} + {3'd0, pen_q};

  // The stop bit always ends up in bit 9 and parity in bit 8; data sits below them.
  assign frame = 8'(shreg_q >> (4'd10 - nsamp));
  assign data  = {eight_q & frame[7], frame[6:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      sync_q     <= '1;
      cnt_q      <= '0;
      bitcnt_q   <= '0;
      shreg_q    <= '0;
      eight_q    <= 1'b0;
      pen_q      <= 1'b0;
      ohel_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_ready_q <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], rx};
      cnt_q      <= cnt_d;
      bitcnt_q   <= bitcnt_d;
      shreg_q    <= shreg_d;
      eight_q    <= eight_d;
      pen_q      <= pen_d;
      ohel_q     <= ohel_d;
      rx_data_q  <= rx_data_d;
      rx_ready_q <= rx_ready_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    bitcnt_d   = bitcnt_q;
    shreg_d    = shreg_q;
    eight_d    = eight_q;
    pen_d      = pen_q;
    ohel_d     = ohel_q;
    rx_data_d  = rx_data_q;
    rx_ready_d = rx_ready_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    ovf_d      = ovf_q;

    if (reads) begin
      rx_ready_d = 1'b0;
      ovf_d      = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (!rxs) begin
          state_d = StStart;
          eight_d = eight;
          pen_d   = pen;
          ohel_d  = ohel;
        end
      end
      StStart: begin
        if (tick) begin
          state_d  = rxs ? StIdle : StData;
          bitcnt_d = '0;
        end else begin
          cnt_d = cnt_q + KW'(1);
        end
      end
      StData: begin
        if (tick) begin
          shreg_d  = {rxs, shreg_q[9:1]};
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_d == nsamp) state_d = StDone;
        end else begin
          cnt_d = cnt_q + KW'(1);
        end
      end
      StDone: begin
        // A read in this cycle loses to the new byte.
        rx_data_d  = data;
        ferr_d     = ~shreg_q[9];
        perr_d     = pen_q & (shreg_q[8] ^ (^data) ^ ohel_q);
        rx_ready_d = 1'b1;
        ovf_d      = rx_ready_q & ~reads;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign rx_data  = rx_data_q;
  assign rx_ready = rx_ready_q;
  assign perr     = perr_q;
  assign ferr     = ferr_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed self-checking bench for uart_rx_engine: frames are driven serially on rx and the
// resulting byte and status flags are compared against hand-computed values.
module tb_uart_rx_engine;
  localparam int KW = 20;

  logic          clk = 1'b0;
  logic          reset, rx, eight, pen, ohel, reads;
  logic [KW-1:0] k;
  logic [7:0]    rx_data;
  logic          rx_ready, perr, ferr, ovf;

  int   n_cmp = 0, n_err = 0;
  int   cyc = 0, start_cyc = 0, rise_cyc = 0, rises = 0;
  logic rdy_prev = 1'b0;

  uart_rx_engine #(.KW(KW), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .rx(rx), .k(k), .eight(eight), .pen(pen), .ohel(ohel),
    .reads(reads), .rx_data(rx_data), .rx_ready(rx_ready), .perr(perr), .ferr(ferr), .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    rdy_prev <= rx_ready;
    if (rx_ready && !rdy_prev) begin
      rise_cyc <= cyc;
      rises    <= rises + 1;
    end
  end

  // Called and returns on a negedge; drives start, data LSB first, optional parity, stop.
  task automatic send_frame(input logic [7:0] d, input logic e8, input logic pe,
                            input logic pb, input logic sb, input int kk);
    int nd;
    nd = e8 ? 8 : 7;
    k = kk[KW-1:0];
    rx = 1'b0;
    start_cyc = cyc;
    repeat (kk) @(negedge clk);
    for (int i = 0; i < nd; i++) begin
      rx = d[i];
      repeat (kk) @(negedge clk);
    end
    if (pe) begin
      rx = pb;
      repeat (kk) @(negedge clk);
    end
    rx = sb;
    repeat (kk) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic do_read();
    reads = 1'b1;
    @(negedge clk);
    reads = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; rx = 1'b1; reads = 1'b0; k = KW'(868);
    eight = 1'b1; pen = 1'b0; ohel = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", rx_data); end
    n_cmp++; if (rx_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", rx_ready); end
    n_cmp++; if (perr !== 1'b0) begin n_err++; $display("FAIL reset_perr: got %b want 0", perr); end
    n_cmp++; if (ferr !== 1'b0) begin n_err++; $display("FAIL reset_ferr: got %b want 0", ferr); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    reset = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_8n1();
    int lat;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 868);
    lat = rise_cyc - start_cyc;
    n_cmp++; if (lat < 8247 || lat > 8251) begin n_err++; $display("FAIL 8n1_latency: got %0d want 8249+-2", lat); end
    n_cmp++; if (rx_data !== 8'hA5) begin n_err++; $display("FAIL 8n1_data: got %h want a5", rx_data); end
    n_cmp++; if (rx_ready !== 1'b1) begin n_err++; $display("FAIL 8n1_ready: got %b want 1", rx_ready); end
    n_cmp++; if ({perr, ferr, ovf} !== 3'b000) begin n_err++; $display("FAIL 8n1_flags: got %b want 000", {perr, ferr, ovf}); end
    do_read();
    n_cmp++; if (rx_ready !== 1'b0) begin n_err++; $display("FAIL 8n1_read_clear: got %b want 0", rx_ready); end
  endtask

  task automatic test_parity();
    eight = 1'b0; pen = 1'b1; ohel = 1'b0;
    send_frame(8'h41, 1'b0, 1'b1, 1'b0, 1'b1, 434);
    n_cmp++; if (rx_data !== 8'h41) begin n_err++; $display("FAIL 7e1_good_data: got %h want 41", rx_data); end
    n_cmp++; if (perr !== 1'b0) begin n_err++; $display("FAIL 7e1_good_perr: got %b want 0", perr); end
    do_read();
    send_frame(8'h41, 1'b0, 1'b1, 1'b1, 1'b1, 434);
    n_cmp++; if (rx_data !== 8'h41) begin n_err++; $display("FAIL 7e1_bad_data: got %h want 41", rx_data); end
    n_cmp++; if (perr !== 1'b1) begin n_err++; $display("FAIL 7e1_bad_perr: got %b want 1", perr); end
    do_read();
    n_cmp++; if (perr !== 1'b1) begin n_err++; $display("FAIL perr_hold_after_read: got %b want 1", perr); end
    // 7O1 with bit 7 set in the source byte; config is flipped to 8N1 mid-frame.
    ohel = 1'b1;
    fork
      send_frame(8'hC1, 1'b0, 1'b1, 1'b1, 1'b1, 64);
      begin
        repeat (192) @(negedge clk);
        eight = 1'b1; pen = 1'b0; ohel = 1'b0;
      end
    join
    n_cmp++; if (rx_data !== 8'h41) begin n_err++; $display("FAIL 7o1_data: got %h want 41", rx_data); end
    n_cmp++; if ({perr, ferr} !== 2'b00) begin n_err++; $display("FAIL 7o1_flags: got %b want 00", {perr, ferr}); end
    do_read();
  endtask

  task automatic test_framing();
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 868);
    rx = 1'b1;
    n_cmp++; if (ferr !== 1'b1) begin n_err++; $display("FAIL ferr_set: got %b want 1", ferr); end
    n_cmp++; if (rx_ready !== 1'b1) begin n_err++; $display("FAIL ferr_ready: got %b want 1", rx_ready); end
    n_cmp++; if (rx_data !== 8'h3C) begin n_err++; $display("FAIL ferr_data: got %h want 3c", rx_data); end
    repeat (1736) @(negedge clk);
    do_read();
    n_cmp++; if (ferr !== 1'b1) begin n_err++; $display("FAIL ferr_hold_after_read: got %b want 1", ferr); end
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 868);
    n_cmp++; if (ferr !== 1'b0) begin n_err++; $display("FAIL ferr_clear: got %b want 0", ferr); end
    n_cmp++; if (rx_data !== 8'h3C) begin n_err++; $display("FAIL ferr_good_data: got %h want 3c", rx_data); end
    do_read();
  endtask

  task automatic test_glitch();
    int r0;
    k = KW'(868);
    r0 = rises;
    rx = 1'b0;
    repeat (200) @(negedge clk);
    rx = 1'b1;
    repeat (1000) @(negedge clk);
    n_cmp++; if (rises !== r0) begin n_err++; $display("FAIL glitch_no_frame: got %0d rises want %0d", rises, r0); end
    n_cmp++; if (rx_ready !== 1'b0) begin n_err++; $display("FAIL glitch_ready: got %b want 0", rx_ready); end
    send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b1, 868);
    n_cmp++; if (rx_data !== 8'h55) begin n_err++; $display("FAIL glitch_next_data: got %h want 55", rx_data); end
    n_cmp++; if (rx_ready !== 1'b1) begin n_err++; $display("FAIL glitch_next_ready: got %b want 1", rx_ready); end
    do_read();
  endtask

  task automatic test_back_to_back();
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 100);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b1, 100);
    n_cmp++; if (rx_data !== 8'h22) begin n_err++; $display("FAIL b2b_data: got %h want 22", rx_data); end
    n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL b2b_ovf: got %b want 1", ovf); end
    n_cmp++; if (rx_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready: got %b want 1", rx_ready); end
    do_read();
    n_cmp++; if ({rx_ready, ovf} !== 2'b00) begin n_err++; $display("FAIL b2b_read_clear: got %b want 00", {rx_ready, ovf}); end
  endtask

  task automatic test_reset_midframe();
    int r0;
    k = KW'(100);
    rx = 1'b0;
    repeat (100) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = (i == 0) ? 1'b1 : 1'b0;
      repeat (100) @(negedge clk);
    end
    rx = 1'b0;
    repeat (50) @(negedge clk);
    reset = 1'b1;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    r0 = rises;
    n_cmp++; if ({rx_ready, perr, ferr, ovf} !== 4'b0000) begin n_err++; $display("FAIL midrst_flags: got %b want 0000", {rx_ready, perr, ferr, ovf}); end
    n_cmp++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL midrst_data: got %h want 00", rx_data); end
    repeat (1200) @(negedge clk);
    n_cmp++; if (rises !== r0) begin n_err++; $display("FAIL midrst_no_frame: got %0d rises want %0d", rises, r0); end
    send_frame(8'hF0, 1'b1, 1'b0, 1'b0, 1'b1, 100);
    n_cmp++; if (rx_data !== 8'hF0) begin n_err++; $display("FAIL midrst_next_data: got %h want f0", rx_data); end
    n_cmp++; if ({rx_ready, perr, ferr, ovf} !== 4'b1000) begin n_err++; $display("FAIL midrst_next_flags: got %b want 1000", {rx_ready, perr, ferr, ovf}); end
  endtask

  task automatic test_read_on_done();
    // rx_ready is still set from the previous frame; reads lands on the DONE cycle.
    fork
      send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 100);
      begin
        @(negedge clk);
        while (cyc < start_cyc + 953) @(negedge clk);
        reads = 1'b1;
        @(negedge clk);
        reads = 1'b0;
      end
    join
    n_cmp++; if (rx_ready !== 1'b1) begin n_err++; $display("FAIL rdone_ready: got %b want 1", rx_ready); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL rdone_ovf: got %b want 0", ovf); end
    n_cmp++; if (rx_data !== 8'h5A) begin n_err++; $display("FAIL rdone_data: got %h want 5a", rx_data); end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_framing();
    test_glitch();
    test_back_to_back();
    test_reset_midframe();
    test_read_on_done();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_engine.md
Name: uart_rx_engine

Overview:
- Receive engine of the UART and the counterpart to the transmit engine.
- Oversamples the asynchronous serial input `rx` against the bit time `k` supplied by the baud decoder, and samples each bit at its centre.
- Assembles 7- or 8-bit frames with optional even/odd parity and checks the parity and stop bits.
- Presents the byte with a ready flag and parity, framing and overflow status to the SoC read interface.

Parameters:
- KW, 20, width of the bit-time count input (matches the baud decoder output).
- SYNC_STAGES, 2, number of flip-flops in the rx input synchronizer (minimum 2).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx  in  1  asynchronous serial line; idles high
- k  in  KW  clocks per bit time, from the baud decoder; legal values are >= 8
- eight  in  1  1 = 8 data bits, 0 = 7 data bits
- pen  in  1  parity enable
- ohel  in  1  parity sense: 1 = odd, 0 = even
- reads  in  1  single-cycle pulse; the CPU has read the data/status
- rx_data  out  8  received byte; bit 7 is forced to 0 in 7-bit mode
- rx_ready  out  1  new byte available
- perr  out  1  parity error on the last frame
- ferr  out  1  framing error (stop bit sampled as 0) on the last frame
- ovf  out  1  overrun: a frame completed while rx_ready was still set

Behaviour:
- Reset (synchronous, active-high):
  - Outputs: rx_data=0, rx_ready=0, perr=0, ferr=0, ovf=0.
  - Internal: state=IDLE, counters=0, synchronizer flops=1.
  - Reset asserted mid-frame aborts the frame; no flags are set.
- Synchronizer: rx passes through SYNC_STAGES flops. All logic uses the synchronized signal rxs, which lags rx by SYNC_STAGES cycles.
- Bit-time counter:
  - Cleared on every state entry and after every tick.
  - Tick fires when the count equals target-1.
  - target = k>>1 in START; target = k in DATA.
- Frame configuration: eight, pen and ohel are latched on the IDLE->START transition; changes mid-frame have no effect on the current frame.
- Number of samples after the start bit: N = 7 + eight + pen + 1 (data bits, then optional parity, then stop). N ranges 8..10.
- IDLE: when rxs==0, go to START.
- START:
  - On the half-bit tick, if rxs==0 go to DATA with bit count 0.
  - If rxs==1, the start is false: return to IDLE with no flag change.
- DATA:
  - On each tick, shift rxs into a 10-bit shift register (LSB first, right shift) and increment the bit count.
  - When bit count reaches N, go to DONE.
- DONE (one cycle), then IDLE:
  - Right-justify the frame according to the latched eight and pen.
  - rx_data <= data bits (bit7=0 when eight=0).
  - ferr <= ~stop bit.
  - perr <= pen & (parity_bit ^ (^data) ^ ohel). Even parity expects ^data; odd parity expects ~^data. perr=0 when pen=0.
  - rx_ready <= 1.
  - ovf <= 1 if rx_ready==1 and reads==0 in this cycle.
- Next frame: a start bit may be detected the cycle after DONE. A stop bit followed immediately by a start edge must be received correctly.
- reads:
  - Clears rx_ready and ovf in the next cycle.
  - If reads and DONE fall in the same cycle, DONE wins: rx_ready stays 1 and ovf is not set.
- perr and ferr hold until the next DONE. reads does not clear them.
- Latency: rx_ready rises SYNC_STAGES + (k>>1) + N*k + 1 cycles after the falling start edge on rx, with ±2 cycles tolerance.
- Invalid k: behaviour for k<8 is undefined. The block must not lock up; any subsequent reset recovers it.

Test Plan:
- k=868, eight=1, pen=0, send 0xA5 8N1 -> rx_ready rises about 8249 cycles after the start edge; rx_data=0xA5; perr=0, ferr=0, ovf=0.
- k=434, eight=0, pen=1, ohel=0 (7E1), send 0x41 with parity 0 -> rx_data=0x41, perr=0. Repeat with parity bit 1 -> perr=1, rx_data=0x41.
- k=868, 8N1, send 0x3C with stop bit driven 0 -> ferr=1, rx_ready=1. Next good frame 0x3C -> ferr=0.
- rx low for 200 cycles only with k=868 (glitch shorter than half a bit) -> no rx_ready; the next valid frame 0x55 is received correctly.
- Two back-to-back frames 0x11 then 0x22 with no reads -> ovf=1 and rx_data=0x22 after the second. A reads pulse clears rx_ready and ovf the next cycle.
- Reset asserted mid-frame during bit 3, then released, then 0xF0 sent -> all flags 0 until 0xF0 completes; rx_data=0xF0. Also: reads asserted on the DONE cycle -> rx_ready remains 1 and ovf=0.
